cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, 4, number of functional-unit requesters; index 0=ALU, 1=MULT, 2=BTU, 3=LSU.
REQ-002 Parameter XLEN, 32, result data width.
REQ-003 Parameter TAG_W, `ROB_TAG_LEN, ROB tag width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 flush  input  1  ROB mispredict squash; synchronous.
REQ-007 fu_valid  input  NUM_FU  per-FU result valid.
REQ-008 fu_tag  input  NUM_FU x TAG_W  per-FU destination ROB tag.
REQ-009 fu_value  input  NUM_FU x XLEN  per-FU result value.
REQ-010 fu_ready  output  NUM_FU  per-FU accept; result is taken when fu_valid[i] & fu_ready[i].
REQ-011 cdb_valid  output  1  registered CDB broadcast valid.
REQ-012 cdb_tag  output  TAG_W  registered broadcast ROB tag.
REQ-013 cdb_value  output  XLEN  registered broadcast value.
REQ-014 cdb_fu  output  2  registered index of FU that won the broadcast.

Function
REQ-015 Each FU SHALL own a one-entry holding buffer (buf_valid, buf_tag, buf_value).
REQ-016 fu_ready[i] SHALL be combinational: ~flush & (~buf_valid[i] | grant[i]).
REQ-017 An accepted result SHALL be written to buffer i at the same edge; a simultaneous grant and accept on i SHALL leave buffer i valid with the new data.
REQ-018 Arbitration SHALL consider only buffered entries, never fu_valid directly.
REQ-019 Grant SHALL be one-hot, round-robin: search from rr_ptr upward modulo NUM_FU; first valid buffer wins.
REQ-020 After a grant to k, rr_ptr SHALL become (k+1) mod NUM_FU; with no grant rr_ptr SHALL hold.
REQ-021 Granted buffer SHALL be cleared (unless refilled per REQ-017) and its tag/value/index registered onto cdb_* at the same edge.
REQ-022 cdb_valid SHALL be 1 for exactly one cycle per grant; when no grant, cdb_valid SHALL be 0 and cdb_tag/cdb_value/cdb_fu SHALL hold previous values.
REQ-023 Latency: fu_valid accepted in cycle N SHALL appear on cdb_valid no earlier than cycle N+2; an uncontended request SHALL appear in exactly N+2.
REQ-024 Throughput: one broadcast per cycle maximum; a continuously requesting FU SHALL sustain one broadcast every NUM_FU cycles under full contention (no starvation).
REQ-025 flush SHALL, at the edge: clear all buf_valid, set cdb_valid to 0, reset rr_ptr to 0; no grant and no accept during a flush cycle.
REQ-026 flush SHALL take priority over any simultaneous accept or grant.
REQ-027 Values SHALL pass through unmodified; no arithmetic on tag or data.

Reset
REQ-028 On reset: all buf_valid=0, rr_ptr=0, cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_fu=0.
REQ-029 During reset, fu_ready SHALL read all-ones only after reset deasserts; while reset=1 no accept SHALL occur.
REQ-030 Reset SHALL dominate flush.

Verification
REQ-031 Single request: ALU valid tag=5 value=0x1234 in cycle 1 -> cdb_valid=1, tag=5, value=0x1234, cdb_fu=0 in cycle 3, cdb_valid=0 in cycle 4.
REQ-032 Full contention: all four FUs valid every cycle, tags 1..4, rr_ptr=0 -> broadcasts in order fu 0,1,2,3,0,... one per cycle; each FU ready only when its buffer drains.
REQ-033 Back-to-back same FU: MULT valid cycles 1-5, tags 10..14, no others -> cdb tags 10..14 consecutive in cycles 3-7, fu_ready[1] never 0.
REQ-034 Rotation: buffers 2 and 3 valid, rr_ptr=3 -> FU3 granted first, then FU2; rr_ptr ends at 3.
REQ-035 Flush mid-operation: buffers 0,1,3 valid, flush=1 -> next cycle cdb_valid=0, all buffers empty, rr_ptr=0; fu_valid during flush cycle is dropped.
REQ-036 Reset mid-operation: reset with cdb_valid=1 and buffers full -> all outputs zero next cycle, fu_ready all-ones after deassert.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Functional-unit result ports and common-data-bus broadcast of the CDB arbiter.
// The master side is the FU/consumer; the slave side is the arbiter.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

interface cdb_arbiter_if #(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned XLEN   = 32,
    parameter int unsigned TAG_W  = `ROB_TAG_LEN
);
    logic [NUM_FU-1:0]            fu_valid;
    logic [NUM_FU-1:0][TAG_W-1:0] fu_tag;
    logic [NUM_FU-1:0][XLEN-1:0]  fu_value;
    logic [NUM_FU-1:0]            fu_ready;
    logic                         cdb_valid;
    logic [TAG_W-1:0]             cdb_tag;
    logic [XLEN-1:0]              cdb_value;
    logic [1:0]                   cdb_fu;

    modport master (
        output fu_valid, fu_tag, fu_value,
        input  fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_fu
    );

    modport slave (
        input  fu_valid, fu_tag, fu_value,
        output fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_fu
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: one holding buffer per functional unit,
// one registered broadcast per cycle, squashed by flush.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module cdb_arbiter #(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned XLEN   = 32,
    parameter int unsigned TAG_W  = `ROB_TAG_LEN
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    cdb_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = 2;

    logic [NUM_FU-1:0]            buf_valid_q, buf_valid_d;
    logic [NUM_FU-1:0][TAG_W-1:0] buf_tag_q, buf_tag_d;
    logic [NUM_FU-1:0][XLEN-1:0]  buf_value_q, buf_value_d;
    logic [IDX_W-1:0]             rr_ptr_q, rr_ptr_d;
    logic                         cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]             cdb_tag_q, cdb_tag_d;
    logic [XLEN-1:0]              cdb_value_q, cdb_value_d;
    logic [IDX_W-1:0]             cdb_fu_q, cdb_fu_d;

    logic [NUM_FU-1:0] grant;
    logic              grant_valid;
    logic [IDX_W-1:0]  grant_idx;
    logic [NUM_FU-1:0] ready;
    logic [NUM_FU-1:0] accept;
    logic [IDX_W-1:0]  cand;

    // Search buffers (never raw fu_valid) starting at rr_ptr; flush blocks any grant.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned off = 0; off < NUM_FU; off++) begin
            cand = IDX_W'((32'(rr_ptr_q) + off) % NUM_FU);
            if (!flush && !grant_valid && buf_valid_q[cand]) begin
                grant_valid  = 1'b1;
                grant_idx    = cand;
                grant[cand]  = 1'b1;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            ready[i] = ~reset & ~flush & (~buf_valid_q[i] | grant[i]);
        end
        accept = bus.fu_valid & ready;
    end

    always_comb begin
        buf_valid_d = buf_valid_q & ~grant;
        buf_tag_d   = buf_tag_q;
        buf_value_d = buf_value_q;
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = grant_valid;
        cdb_tag_d   = cdb_tag_q;
        cdb_value_d = cdb_value_q;
        cdb_fu_d    = cdb_fu_q;

        // A refill on a granted FU lands after the clear, so the buffer stays full.
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (accept[i]) begin
                buf_valid_d[i] = 1'b1;
                buf_tag_d[i]   = bus.fu_tag[i];
                buf_value_d[i] = bus.fu_value[i];
            end
        end

        if (grant_valid) begin
            cdb_tag_d   = buf_tag_q[grant_idx];
            cdb_value_d = buf_value_q[grant_idx];
            cdb_fu_d    = grant_idx;
            rr_ptr_d    = (grant_idx == IDX_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
        end

        if (flush) begin
            buf_valid_d = '0;
            rr_ptr_d    = '0;
            cdb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid_q <= '0;
            buf_tag_q   <= '0;
            buf_value_q <= '0;
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
            cdb_fu_q    <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_value_q <= buf_value_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_value_q <= cdb_value_d;
            cdb_fu_q    <= cdb_fu_d;
        end
    end

    assign bus.fu_ready  = ready;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_value = cdb_value_q;
    assign bus.cdb_fu    = cdb_fu_q;
endmodule
